// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizing constants for the CPU register file
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_NUM    = 1 << DEF_ADDR_W;
    localparam int COUNT_W    = 32;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file, r0 hardwired to zero, with debug read and write statistics
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writingAddress,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [ADDR_W-1:0]          rs,
    input  logic [ADDR_W-1:0]          rt,
    output logic [DATA_W-1:0]          readData1,
    output logic [DATA_W-1:0]          readData2,
    input  logic [ADDR_W-1:0]          debugAddr,
    output logic [DATA_W-1:0]          debugData,
    output logic [(1 << ADDR_W)-1:0]   writtenMap,
    output logic [COUNT_W-1:0]         writeCount
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              commit;

    assign commit = regWrite && (writingAddress != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            writtenMap <= '0;
            writeCount <= '0;
        end else if (commit) begin
            regs[writingAddress]       <= writeData;
            writtenMap[writingAddress] <= 1'b1;
            writeCount                 <= writeCount + 1'b1;
        end
    end

    // No bypass from the write port: same-cycle reads see the pre-edge value.
    always_comb begin
        readData1 = (rs == '0)        ? '0 : regs[rs];
        readData2 = (rt == '0)        ? '0 : regs[rt];
        debugData = (debugAddr == '0) ? '0 : regs[debugAddr];
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file against a behavioural model
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        regWrite;
    logic [4:0]  writingAddress;
    logic [31:0] writeData;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [4:0]  debugAddr;
    logic [31:0] debugData;
    logic [31:0] writtenMap;
    logic [31:0] writeCount;

    reg_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .regWrite      (regWrite),
        .writingAddress(writingAddress),
        .writeData     (writeData),
        .rs            (rs),
        .rt            (rt),
        .readData1     (readData1),
        .readData2     (readData2),
        .debugAddr     (debugAddr),
        .debugData     (debugData),
        .writtenMap    (writtenMap),
        .writeCount    (writeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdlRegs [32];
    logic [31:0] mdlMap;
    logic [31:0] mdlCount;
    logic [31:0] sbQ [$];
    string       sbTagQ [$];
    int          testCount;
    int          failCount;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mdlReset();
        for (int i = 0; i < 32; i++) mdlRegs[i] = '0;
        mdlMap   = '0;
        mdlCount = '0;
    endtask

    task automatic sbPush(input string tag, input logic [31:0] val);
        sbTagQ.push_back(tag);
        sbQ.push_back(val);
    endtask

    task automatic sbPop(input logic [31:0] got);
        string       tag;
        logic [31:0] exp;
        if (sbQ.size() == 0) begin
            checkVal("sb_underflow", got, 32'hxxxx_xxxx);
        end else begin
            tag = sbTagQ.pop_front();
            exp = sbQ.pop_front();
            checkVal(tag, got, exp);
        end
    endtask

    // Push model expectations for the three read ports, settle, then pop them.
    task automatic readAll(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        rs        = a1;
        rt        = a2;
        debugAddr = a3;
        sbPush($sformatf("rd1[%0d]", a1), (a1 == 0) ? 32'h0 : mdlRegs[a1]);
        sbPush($sformatf("rd2[%0d]", a2), (a2 == 0) ? 32'h0 : mdlRegs[a2]);
        sbPush($sformatf("dbg[%0d]", a3), (a3 == 0) ? 32'h0 : mdlRegs[a3]);
        #1;
        sbPop(readData1);
        sbPop(readData2);
        sbPop(debugData);
    endtask

    task automatic checkStatus(input string tag);
        checkVal({tag, "_map"}, writtenMap, mdlMap);
        checkVal({tag, "_count"}, writeCount, mdlCount);
    endtask

    task automatic doWrite(input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        regWrite       = we;
        writingAddress = a;
        writeData      = d;
        @(posedge clk);
        if (we && a != 0) begin
            mdlRegs[a] = d;
            mdlMap[a]  = 1'b1;
            mdlCount   = mdlCount + 1;
        end
        #1;
        regWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        testCount      = 0;
        failCount      = 0;
        rst_n          = 1'b0;
        regWrite       = 1'b0;
        writingAddress = '0;
        writeData      = '0;
        rs             = '0;
        rt             = '0;
        debugAddr      = '0;
        mdlReset();
        #12;
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) readAll(i[4:0], 5'(31 - i), i[4:0]);
        checkStatus("reset");

        doWrite(1'b1, 5'd5, 32'hDEAD_BEEF);
        readAll(5'd5, 5'd0, 5'd5);
        checkVal("r5_map_const", writtenMap, 32'h0000_0020);
        checkVal("r5_count_const", writeCount, 32'd1);

        doWrite(1'b1, 5'd0, 32'h1234_5678);
        readAll(5'd0, 5'd0, 5'd0);
        checkStatus("r0_write");

        doWrite(1'b0, 5'd9, 32'h5555_AAAA);
        readAll(5'd9, 5'd9, 5'd9);
        checkStatus("no_we");

        doWrite(1'b1, 5'd7, 32'h1);
        @(negedge clk);
        regWrite       = 1'b1;
        writingAddress = 5'd7;
        writeData      = 32'h2;
        readAll(5'd7, 5'd7, 5'd7);
        checkVal("bypass_before", readData1, 32'h1);
        @(posedge clk);
        mdlRegs[7] = 32'h2;
        mdlCount   = mdlCount + 1;
        #1;
        regWrite = 1'b0;
        readAll(5'd7, 5'd7, 5'd7);
        checkVal("bypass_after", readData2, 32'h2);

        doWrite(1'b1, 5'd3, 32'hA);
        doWrite(1'b1, 5'd31, 32'hB);
        readAll(5'd3, 5'd31, 5'd31);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mdlReset();
        #1;
        readAll(5'd3, 5'd31, 5'd3);
        checkStatus("async_reset");
        doWrite(1'b1, 5'd3, 32'h5);
        mdlReset();
        readAll(5'd3, 5'd3, 5'd3);
        checkStatus("reset_held");
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            doWrite(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
            readAll(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        checkStatus("random");

        @(negedge clk);
        force dut.writeCount = 32'hFFFF_FFFE;
        #1;
        release dut.writeCount;
        mdlCount = 32'hFFFF_FFFE;
        checkStatus("preload");
        doWrite(1'b1, 5'd12, 32'h0BAD_F00D);
        checkStatus("count_max");
        doWrite(1'b1, 5'd13, 32'hCAFE_0001);
        checkStatus("count_wrap");
        checkVal("wrap_const", writeCount, 32'h0);
        doWrite(1'b1, 5'd14, 32'hCAFE_0002);
        checkStatus("count_after_wrap");
        for (int i = 0; i < 32; i++) readAll(i[4:0], i[4:0], 5'(31 - i));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
